// File: rtl/vend_ctrl.sv
// Vending machine transaction sequencer: credit accumulation, price check,
// vend strobe and paced change return. All outputs come straight from registers.
module vend_ctrl #(
    parameter int CREDIT_W   = 8,
    parameter int COIN_VAL   = 10,
    parameter int PRICE_BASE = 20,
    parameter int PRICE_STEP = 10,
    parameter int MAX_CREDIT = 90,
    parameter int CHANGE_GAP = 3,
    parameter int ERR_HOLD   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_pulse,
    input  logic                buy_pulse,
    input  logic                cancel_pulse,
    input  logic [3:0]          item_sel,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_valid,
    output logic [1:0]          vend_item,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                err,
    output logic                busy,
    output logic [2:0]          state_code
);

    localparam int GAP_W  = $clog2(CHANGE_GAP + 1);
    localparam int HOLD_W = $clog2(ERR_HOLD + 1);

    localparam logic [CREDIT_W-1:0] COIN_C     = CREDIT_W'(COIN_VAL);
    localparam logic [CREDIT_W-1:0] COIN_LIMIT = CREDIT_W'(MAX_CREDIT - COIN_VAL);
    localparam logic [GAP_W-1:0]    GAP_RELOAD = GAP_W'(CHANGE_GAP - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LOAD  = HOLD_W'(ERR_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CREDIT = 3'd1,
        ST_VEND   = 3'd2,
        ST_CHANGE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [1:0]          vend_item_reg, vend_item_next;
    logic                vend_valid_reg, vend_valid_next;
    logic                change_pulse_reg, change_pulse_next;
    logic                coin_reject_reg, coin_reject_next;
    logic                err_reg, err_next;
    logic                busy_reg, busy_next;
    logic [GAP_W-1:0]    gap_reg, gap_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;

    logic [CREDIT_W-1:0] price_tbl [4];
    logic [1:0]          sel_idx;
    logic                sel_onehot;
    logic [CREDIT_W-1:0] remainder;

    for (genvar gi = 0; gi < 4; gi++) begin : g_price
        assign price_tbl[gi] = CREDIT_W'(PRICE_BASE + gi * PRICE_STEP);
    end

    assign sel_onehot = ($countones(item_sel) == 1);

    always_comb begin
        sel_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (item_sel[i]) begin
                sel_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            credit_reg       <= '0;
            vend_item_reg    <= '0;
            vend_valid_reg   <= 1'b0;
            change_pulse_reg <= 1'b0;
            coin_reject_reg  <= 1'b0;
            err_reg          <= 1'b0;
            busy_reg         <= 1'b0;
            gap_reg          <= '0;
            hold_reg         <= '0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            vend_item_reg    <= vend_item_next;
            vend_valid_reg   <= vend_valid_next;
            change_pulse_reg <= change_pulse_next;
            coin_reject_reg  <= coin_reject_next;
            err_reg          <= err_next;
            busy_reg         <= busy_next;
            gap_reg          <= gap_next;
            hold_reg         <= hold_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        credit_next       = credit_reg;
        vend_item_next    = vend_item_reg;
        vend_valid_next   = 1'b0;
        change_pulse_next = 1'b0;
        coin_reject_next  = 1'b0;
        err_next          = 1'b0;
        gap_next          = gap_reg;
        hold_next         = hold_reg;
        remainder         = credit_reg - price_tbl[vend_item_reg];

        case (state_reg)
            ST_IDLE: begin
                if (coin_pulse) begin
                    credit_next = COIN_C;
                    state_next  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (cancel_pulse) begin
                    // Every entry into CHANGE pays its first coin on the entry edge.
                    state_next        = ST_CHANGE;
                    credit_next       = credit_reg - COIN_C;
                    change_pulse_next = 1'b1;
                    gap_next          = GAP_RELOAD;
                    coin_reject_next  = coin_pulse;
                end else if (buy_pulse) begin
                    coin_reject_next = coin_pulse;
                    if (!sel_onehot || credit_reg < price_tbl[sel_idx]) begin
                        state_next = ST_ERROR;
                        err_next   = 1'b1;
                        hold_next  = HOLD_LOAD;
                    end else begin
                        state_next     = ST_VEND;
                        vend_item_next = sel_idx;
                    end
                end else if (coin_pulse) begin
                    if (credit_reg <= COIN_LIMIT) begin
                        credit_next = credit_reg + COIN_C;
                    end else begin
                        coin_reject_next = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                coin_reject_next = coin_pulse;
                vend_valid_next  = 1'b1;
                if (remainder != '0) begin
                    state_next        = ST_CHANGE;
                    credit_next       = remainder - COIN_C;
                    change_pulse_next = 1'b1;
                    gap_next          = GAP_RELOAD;
                end else begin
                    state_next  = ST_IDLE;
                    credit_next = '0;
                end
            end
            ST_CHANGE: begin
                coin_reject_next = coin_pulse;
                if (credit_reg == '0) begin
                    state_next = ST_IDLE;
                    gap_next   = '0;
                end else if (gap_reg == '0) begin
                    credit_next       = credit_reg - COIN_C;
                    change_pulse_next = 1'b1;
                    gap_next          = GAP_RELOAD;
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end
            ST_ERROR: begin
                coin_reject_next = coin_pulse;
                if (hold_reg == '0) begin
                    state_next = ST_CREDIT;
                end else begin
                    err_next  = 1'b1;
                    hold_next = hold_reg - 1'b1;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                credit_next = '0;
            end
        endcase

        busy_next = (state_next == ST_VEND) || (state_next == ST_CHANGE) ||
                    (state_next == ST_ERROR);
    end

    assign credit       = credit_reg;
    assign vend_valid   = vend_valid_reg;
    assign vend_item    = vend_item_reg;
    assign change_pulse = change_pulse_reg;
    assign coin_reject  = coin_reject_reg;
    assign err          = err_reg;
    assign busy         = busy_reg;
    assign state_code   = state_reg;

endmodule
